// File: rtl/wb_port_scheduler.sv
// Regfile write-port arbiter between in-order writeback and a buffered MUL/DIV result,
// with a pending-register scoreboard that drives the decode hazard.
module wb_port_scheduler #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_wb_valid,
  input  logic [4:0]  pipe_wb_dest,
  input  logic [31:0] pipe_wb_data,
  output logic        pipe_wb_ready,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_dest,
  input  logic        mdu_done_valid,
  input  logic [4:0]  mdu_done_dest,
  input  logic [31:0] mdu_done_data,
  output logic        mdu_done_ready,
  input  logic [4:0]  dec_src_a,
  input  logic [4:0]  dec_src_b,
  input  logic [4:0]  dec_dest,
  output logic        hazard,
  output logic        rf_load,
  output logic [4:0]  rf_dest,
  output logic [31:0] rf_in
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned CNT_W  = 4;

  logic [NREG-1:0]   sb_q, sb_d;
  logic              buf_valid_q, buf_valid_d;
  logic [REG_W-1:0]  buf_dest_q, buf_dest_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic pipe_req;
  logic mdu_prio;
  logic drain;
  logic done_hs;

  // Port arbitration: the buffered MDU result wins when the pipe is idle or it has starved long enough.
  always_comb begin
    pipe_req = pipe_wb_valid && (pipe_wb_dest != '0);
    mdu_prio = buf_valid_q && (wait_cnt_q == CNT_W'(MAX_WAIT));
    drain    = buf_valid_q && (!pipe_req || mdu_prio);
    done_hs  = mdu_done_valid && (!buf_valid_q || drain);
  end

  // Regfile and handshake outputs; everything is forced quiet while reset is asserted.
  always_comb begin
    rf_load        = 1'b0;
    rf_dest        = '0;
    rf_in          = '0;
    pipe_wb_ready  = 1'b1;
    mdu_done_ready = 1'b0;
    hazard         = 1'b0;
    if (rst_n) begin
      if (drain) begin
        rf_load = 1'b1;
        rf_dest = buf_dest_q;
        rf_in   = buf_data_q;
      end else if (pipe_req) begin
        rf_load = 1'b1;
        rf_dest = pipe_wb_dest;
        rf_in   = pipe_wb_data;
      end
      pipe_wb_ready  = !(pipe_req && drain);
      mdu_done_ready = !buf_valid_q || drain;
      hazard = ((dec_src_a != '0) && sb_q[dec_src_a]) ||
               ((dec_src_b != '0) && sb_q[dec_src_b]) ||
               ((dec_dest  != '0) && sb_q[dec_dest]);
    end
  end

  // Holding buffer and starvation counter; a result for x0 is accepted but never buffered.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_dest_d  = buf_dest_q;
    buf_data_d  = buf_data_q;
    wait_cnt_d  = wait_cnt_q;
    if (done_hs) begin
      buf_valid_d = (mdu_done_dest != '0);
      buf_dest_d  = mdu_done_dest;
      buf_data_d  = mdu_done_data;
    end else if (drain) begin
      buf_valid_d = 1'b0;
    end
    if (drain || !buf_valid_q) begin
      wait_cnt_d = '0;
    end else if (pipe_req && (wait_cnt_q < CNT_W'(MAX_WAIT))) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Scoreboard: a same-cycle issue overrides the drain clear.
  always_comb begin
    sb_d = sb_q;
    if (drain) begin
      sb_d[buf_dest_q] = 1'b0;
    end
    if (mdu_issue && (mdu_issue_dest != '0)) begin
      sb_d[mdu_issue_dest] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q        <= '0;
      buf_valid_q <= 1'b0;
      buf_dest_q  <= '0;
      buf_data_q  <= '0;
      wait_cnt_q  <= '0;
    end else begin
      sb_q        <= sb_d;
      buf_valid_q <= buf_valid_d;
      buf_dest_q  <= buf_dest_d;
      buf_data_q  <= buf_data_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench: expected regfile writes are queued per cycle and checked by a monitor at negedge.
module tb_wb_port_scheduler;

  logic        clk;
  logic        rst_n;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_dest;
  logic [31:0] pipe_wb_data;
  logic        pipe_wb_ready;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_dest;
  logic        mdu_done_valid;
  logic [4:0]  mdu_done_dest;
  logic [31:0] mdu_done_data;
  logic        mdu_done_ready;
  logic [4:0]  dec_src_a;
  logic [4:0]  dec_src_b;
  logic [4:0]  dec_dest;
  logic        hazard;
  logic        rf_load;
  logic [4:0]  rf_dest;
  logic [31:0] rf_in;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec;
  int  n_bad;
  bit  allow_haz;

  wb_port_scheduler #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_dest(pipe_wb_dest), .pipe_wb_data(pipe_wb_data),
    .pipe_wb_ready(pipe_wb_ready),
    .mdu_issue(mdu_issue), .mdu_issue_dest(mdu_issue_dest),
    .mdu_done_valid(mdu_done_valid), .mdu_done_dest(mdu_done_dest), .mdu_done_data(mdu_done_data),
    .mdu_done_ready(mdu_done_ready),
    .dec_src_a(dec_src_a), .dec_src_b(dec_src_b), .dec_dest(dec_dest), .hazard(hazard),
    .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mdu_issue      = 1'b0;
    mdu_done_valid = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] d);
    mdu_issue      = 1'b1;
    mdu_issue_dest = d;
  endtask

  task automatic done(input logic [4:0] d, input logic [31:0] v);
    mdu_done_valid = 1'b1;
    mdu_done_dest  = d;
    mdu_done_data  = v;
  endtask

  task automatic expect_wr(input logic [4:0] d, input logic [31:0] v);
    wr_t e;
    e.dest = d;
    e.data = v;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    pipe_wb_valid = 1'b0; pipe_wb_dest = '0; pipe_wb_data = '0;
    mdu_issue = 1'b0; mdu_issue_dest = '0;
    mdu_done_valid = 1'b0; mdu_done_dest = '0; mdu_done_data = '0;
    dec_src_a = '0; dec_src_b = '0; dec_dest = '0;
    allow_haz = 1'b0;
    n_vec = 0;
    n_bad = 0;

    // Monitor: every cycle out of reset, pop one expectation per regfile write.
    fork
      forever begin
        wr_t e;
        @(negedge clk);
        if (rst_n) begin
          if (mdu_issue && !allow_haz) chk("decode_contract_hazard", 32'(hazard), 32'd0);
          if (rf_load) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_bad++;
              $display("FAIL rf_unexpected_write: got dest=%0d data=%h expected no write at %0t",
                       rf_dest, rf_in, $time);
            end else begin
              e = exp_q.pop_front();
              chk("rf_dest", 32'(rf_dest), 32'(e.dest));
              chk("rf_in", rf_in, e.data);
            end
          end else begin
            chk("rf_idle_dest", 32'(rf_dest), 32'd0);
            chk("rf_idle_in", rf_in, 32'd0);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              n_vec++;
              n_bad++;
              $display("FAIL rf_missing_write: got no write expected dest=%0d data=%h at %0t",
                       e.dest, e.data, $time);
            end
          end
        end
      end
    join_none

    // Reset state
    #3;
    chk("rst_rf_load", 32'(rf_load), 32'd0);
    chk("rst_pipe_ready", 32'(pipe_wb_ready), 32'd1);
    chk("rst_done_ready", 32'(mdu_done_ready), 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_done_ready", 32'(mdu_done_ready), 32'd1);
    chk("post_rst_hazard", 32'(hazard), 32'd0);
    step();

    // Idle drain of x5
    issue(5'd5); mid(); step();
    dec_src_a = 5'd5; mid();
    chk("idle_haz_pending", 32'(hazard), 32'd1);
    step();
    step();
    done(5'd5, 32'h0000_00AA); mid();
    chk("idle_done_ready", 32'(mdu_done_ready), 32'd1);
    step();
    expect_wr(5'd5, 32'h0000_00AA); mid();
    chk("idle_haz_no_bypass", 32'(hazard), 32'd1);
    chk("idle_pipe_ready", 32'(pipe_wb_ready), 32'd1);
    step();
    mid();
    chk("idle_haz_cleared", 32'(hazard), 32'd0);
    dec_src_a = '0;
    step();

    // Starvation: x7 buffered under continuous pipe traffic x1..x9
    issue(5'd7); mid(); step();
    done(5'd7, 32'h0000_0077); mid(); step();
    begin
      int i;
      i = 1;
      for (int cyc = 0; cyc < 10; cyc++) begin
        pipe_wb_valid = 1'b1;
        pipe_wb_dest  = 5'(i);
        pipe_wb_data  = 32'h100 + 32'(i);
        if (cyc == 4) expect_wr(5'd7, 32'h0000_0077);
        else          expect_wr(5'(i), 32'h100 + 32'(i));
        mid();
        chk("starve_pipe_ready", 32'(pipe_wb_ready), (cyc == 4) ? 32'd0 : 32'd1);
        if (cyc == 5) chk("starve_wait_cnt_cleared", 32'(dut.wait_cnt_q), 32'd0);
        if (cyc != 4) i++;
        step();
      end
    end
    pipe_wb_valid = 1'b0;

    // Same-cycle drain of x3 and refill with x4
    issue(5'd3); mid(); step();
    issue(5'd4); mid(); step();
    done(5'd3, 32'h0000_0033); mid(); step();
    done(5'd4, 32'h0000_1234); expect_wr(5'd3, 32'h0000_0033);
    dec_src_a = 5'd3; dec_src_b = 5'd4; mid();
    chk("refill_done_ready", 32'(mdu_done_ready), 32'd1);
    chk("refill_haz_both", 32'(hazard), 32'd1);
    step();
    expect_wr(5'd4, 32'h0000_1234);
    dec_src_a = 5'd3; dec_src_b = '0; mid();
    chk("refill_sb3_clear", 32'(hazard), 32'd0);
    dec_src_a = 5'd4;
    #1 chk("refill_sb4_pending", 32'(hazard), 32'd1);
    step();
    mid();
    chk("refill_sb4_clear", 32'(hazard), 32'd0);
    dec_src_a = '0;
    step();

    // x0 handling
    issue(5'd6); mid(); step();
    done(5'd6, 32'h0000_0066); mid(); step();
    pipe_wb_valid = 1'b1; pipe_wb_dest = '0; pipe_wb_data = 32'hDEAD_0000;
    expect_wr(5'd6, 32'h0000_0066); mid();
    chk("x0_pipe_ready", 32'(pipe_wb_ready), 32'd1);
    step();
    pipe_wb_valid = 1'b0;
    done(5'd0, 32'hBEEF_0000); mid();
    chk("x0_done_ready", 32'(mdu_done_ready), 32'd1);
    step();
    mid();
    chk("x0_buf_stays_empty", 32'(mdu_done_ready), 32'd1);
    step();

    // Hazard terms and issue-during-drain
    issue(5'd9); mid(); step();
    dec_src_a = 5'd9; mid();
    chk("haz_src_a", 32'(hazard), 32'd1);
    dec_src_a = '0; dec_src_b = 5'd9;
    #1 chk("haz_src_b", 32'(hazard), 32'd1);
    dec_src_b = '0; dec_dest = 5'd9;
    #1 chk("haz_dest", 32'(hazard), 32'd1);
    dec_dest = '0;
    #1 chk("haz_x0_operands", 32'(hazard), 32'd0);
    step();
    done(5'd9, 32'h0000_0099); mid(); step();
    expect_wr(5'd9, 32'h0000_0099);
    allow_haz = 1'b1; issue(5'd9); dec_dest = 5'd9; mid(); step();
    allow_haz = 1'b0; dec_dest = '0;
    dec_src_a = 5'd9; mid();
    chk("haz_set_wins_over_clear", 32'(hazard), 32'd1);
    step();
    done(5'd9, 32'h0000_0999); mid(); step();
    expect_wr(5'd9, 32'h0000_0999); mid(); step();
    mid();
    chk("haz_x9_final_clear", 32'(hazard), 32'd0);
    dec_src_a = '0;
    step();

    // Asynchronous reset in the middle of a drain with x5 and x9 pending
    issue(5'd5); mid(); step();
    issue(5'd9); mid(); step();
    done(5'd5, 32'h0000_0055); mid(); step();
    dec_src_a = 5'd9;
    #1;
    chk("midrst_pre_rf_load", 32'(rf_load), 32'd1);
    chk("midrst_pre_rf_dest", 32'(rf_dest), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("midrst_rf_load", 32'(rf_load), 32'd0);
    chk("midrst_pipe_ready", 32'(pipe_wb_ready), 32'd1);
    chk("midrst_done_ready", 32'(mdu_done_ready), 32'd0);
    chk("midrst_hazard", 32'(hazard), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_done_ready", 32'(mdu_done_ready), 32'd1);
    chk("midrst_release_haz_x9", 32'(hazard), 32'd0);
    dec_src_a = 5'd5; dec_src_b = 5'd9;
    mid();
    chk("midrst_release_haz_x5_x9", 32'(hazard), 32'd0);
    dec_src_a = '0; dec_src_b = '0;
    step();

    repeat (3) step();
    chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
